// File: rtl/arbitro_serial.sv
// rtl/arbitro_serial.sv - round-robin slot arbiter feeding a parallel-load serializer
module arbitro_serial #(
    parameter int                   CANT_BITS = 10,
    parameter logic [CANT_BITS-1:0] IDLE_WORD = 10'b0101111100
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     habilitar,
    input  logic [3:0]               req,
    input  logic [4*CANT_BITS-1:0]   datos,
    output logic [3:0]               ack,
    output logic [CANT_BITS-1:0]     palabra,
    output logic                     cargar,
    output logic                     valido,
    output logic [1:0]               idx,
    output logic [15:0]              palabrasEnviadas
);

    localparam int CW = (CANT_BITS > 1) ? $clog2(CANT_BITS) : 1;
    localparam logic [CW-1:0] C_ULTIMO = CW'(CANT_BITS - 1);

    typedef enum logic [1:0] {
        SINC  = 2'd0,
        LIBRE = 2'd1,
        DATOS = 2'd2
    } estado_t;

    estado_t              r_estado;
    estado_t              w_estado_sig;
    logic [CW-1:0]        r_cont;
    logic [CANT_BITS-1:0] r_palabra;
    logic [3:0]           r_ack;
    logic [1:0]           r_idx;
    logic [1:0]           r_ultimo_idx;
    logic [15:0]          r_enviadas;

    logic                 w_frontera;
    logic                 w_conceder;
    logic [1:0]           w_base;
    logic [7:0]           w_req_doble;
    logic [3:0]           w_req_rot;
    logic [1:0]           w_desplaz;
    logic [1:0]           w_ganador;

    // The last cycle of a slot is the only moment requests are looked at.
    assign w_frontera  = (r_cont == C_ULTIMO);
    assign w_conceder  = w_frontera & habilitar & (|req);

    // Round-robin: rotate req so the slot after the last winner sits at bit 0,
    // then take the lowest set bit and rotate the position back.
    assign w_base      = r_ultimo_idx + 2'd1;
    assign w_req_doble = {req, req};
    assign w_req_rot   = w_req_doble[w_base +: 4];

    // Priority pick on the rotated request vector.
    always_comb begin
        w_desplaz = 2'd0;
        if (w_req_rot[0]) begin
            w_desplaz = 2'd0;
        end else if (w_req_rot[1]) begin
            w_desplaz = 2'd1;
        end else if (w_req_rot[2]) begin
            w_desplaz = 2'd2;
        end else begin
            w_desplaz = 2'd3;
        end
    end

    assign w_ganador = w_base + w_desplaz;

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_estado <= SINC;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next state: SINC lasts one cycle; every slot boundary picks DATOS or LIBRE.
    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            SINC:    w_estado_sig = LIBRE;
            LIBRE:   w_estado_sig = LIBRE;
            DATOS:   w_estado_sig = DATOS;
            default: w_estado_sig = SINC;
        endcase
        if (w_frontera) begin
            w_estado_sig = w_conceder ? DATOS : LIBRE;
        end
    end

    // Slot counter, word register, grant pulse and grant bookkeeping.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_cont       <= '0;
            r_palabra    <= IDLE_WORD;
            r_ack        <= 4'd0;
            r_idx        <= 2'd0;
            r_ultimo_idx <= 2'd3;
            r_enviadas   <= 16'd0;
        end else begin
            r_ack <= 4'd0;
            if (w_frontera) begin
                r_cont <= '0;
                if (w_conceder) begin
                    r_palabra    <= datos[w_ganador*CANT_BITS +: CANT_BITS];
                    r_ack        <= 4'b0001 << w_ganador;
                    r_idx        <= w_ganador;
                    r_ultimo_idx <= w_ganador;
                    r_enviadas   <= r_enviadas + 16'd1;
                end else begin
                    r_palabra <= IDLE_WORD;
                end
            end else begin
                r_cont <= r_cont + CW'(1);
            end
        end
    end

    // The load strobe marks the first cycle of each slot; it is held low while
    // reset is asserted even though the counter already sits at zero.
    assign cargar           = rstN & (r_cont == '0);
    assign valido           = (r_estado == DATOS);
    assign palabra          = r_palabra;
    assign ack              = r_ack;
    assign idx              = r_idx;
    assign palabrasEnviadas = r_enviadas;

endmodule

// File: doc/arbitro_serial.md
ARBITRO_SERIAL -- requirements
Module: arbitro_serial

Interface
REQ-001 Parameter CANT_BITS, default 10, SHALL give serializer word width and slot length in clock cycles.
REQ-002 Parameter IDLE_WORD, default 10'b0101111100, SHALL give the word sent when no requester is granted.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rstN  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 habilitar  input  1  SHALL permit granting new requests when high.
REQ-006 req  input  4  SHALL carry per-requester level requests; bit i for requester i.
REQ-007 datos  input  4*CANT_BITS  SHALL carry requester words; requester i on bits [i*CANT_BITS +: CANT_BITS].
REQ-008 ack  output  4  SHALL carry one-hot, one-cycle grant acknowledgements.
REQ-009 palabra  output  CANT_BITS  SHALL be the registered word driven to the serializer's parallel input.
REQ-010 cargar  output  1  SHALL be the load/counter-reset strobe to the serializer.
REQ-011 valido  output  1  SHALL be high while palabra holds requester data, low while it holds IDLE_WORD.
REQ-012 idx  output  2  SHALL give the index of the requester currently owning the slot.
REQ-013 palabrasEnviadas  output  16  SHALL count granted words.

Function
REQ-014 An internal slot counter contBits SHALL count 0..CANT_BITS-1 and wrap to 0; slot boundary = cycle with contBits==CANT_BITS-1.
REQ-015 FSM states SHALL be SINC, LIBRE, DATOS.
REQ-016 SINC SHALL last exactly one cycle after reset release: cargar=1, palabra=IDLE_WORD, contBits=0; then go to LIBRE.
REQ-017 At each slot boundary, if habilitar==1 and req!=0, the block SHALL grant one requester and enter DATOS on the next edge; otherwise it SHALL enter LIBRE.
REQ-018 Grant selection SHALL be round-robin: search order starts at (ultimoIdx+1) mod 4, where ultimoIdx is the last granted index.
REQ-019 On the edge ending a boundary cycle with a grant: palabra<=datos of winner, ack[winner]<=1, idx<=winner, valido<=1, ultimoIdx<=winner, palabrasEnviadas incremented.
REQ-020 On the edge ending a boundary cycle without a grant: palabra<=IDLE_WORD, valido<=0, ack<=0, idx and ultimoIdx unchanged.
REQ-021 cargar SHALL be high exactly in cycles where contBits==0 (first cycle of every slot, including SINC), low otherwise.
REQ-022 palabra, idx, valido SHALL remain constant for all CANT_BITS cycles of a slot.
REQ-023 ack SHALL be high only in the contBits==0 cycle of the granted slot; never more than one bit set.
REQ-024 Requester handshake: req held high with datos stable until ack seen; a req dropped before the boundary cycle SHALL NOT be granted.
REQ-025 A requester keeping req high after ack SHALL be treated as a new request, still subject to round-robin.
REQ-026 habilitar low at a boundary SHALL suppress grants only; the slot in progress completes unchanged.
REQ-027 palabrasEnviadas SHALL wrap 16'hFFFF -> 16'h0000 without flag.
REQ-028 req and datos SHALL be sampled only in boundary cycles; changes elsewhere SHALL have no effect.

Reset
REQ-029 rstN low SHALL immediately force: state=SINC, contBits=0, palabra=IDLE_WORD, cargar=0, ack=0, valido=0, idx=0, ultimoIdx=3, palabrasEnviadas=0.
REQ-030 Reset asserted mid-slot SHALL abort the slot; no ack SHALL be reissued for the aborted word; after release the sequence restarts at SINC.

Verification
REQ-031 Reset release, req=0 for 30 cycles -> cargar high in cycles 0,10,20; palabra=IDLE_WORD; valido=0; ack=0.
REQ-032 req=4'b0001, datos0=10'h2A5 held -> ack=4'b0001 for one cycle at next slot start, palabra=10'h2A5, valido=1, idx=0 for 10 cycles, palabrasEnviadas=1.
REQ-033 req=4'b1111 held from reset -> grant order 0,1,2,3,0 on consecutive slots; ack one-hot each time.
REQ-034 req=4'b0100 with habilitar=0 for 2 slots, then habilitar=1 -> two IDLE slots, then requester 2 granted at the following boundary.
REQ-035 req=4'b0010 dropped at contBits==5 of preceding slot -> no grant, IDLE slot.
REQ-036 rstN pulsed low at contBits==4 of a DATOS slot -> outputs at reset values immediately, one SINC cycle after release, palabrasEnviadas=0.
